// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: denominations, refund width, dispenser state encoding.
package vm_pkg;

  localparam int VM_VALUE_W = 8;

  localparam int DENOM10 = 10;
  localparam int DENOM5  = 5;
  localparam int DENOM1  = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_EJECT  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } disp_state_e;

  typedef enum logic [1:0] {
    D_1  = 2'd0,
    D_5  = 2'd1,
    D_10 = 2'd2
  } denom_e;

endpackage

// File: rtl/eject_timer.sv
// Loadable down-counter timing the eject timeout and inter-coin gap windows.
module eject_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire,
  output logic         running
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - 1'b1;
    end
  end

  // A load of N expires on the (N+1)th cycle after the load edge.
  assign expire = running && (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Refund payout: greedy 10/5/1 coin ejection with drop-sensor handshake, inventory and jam tracking.
// Optional build macro LOW_STOCK_EN adds the low_stock output and LOW_THRESH parameter.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int VALUE_W    = VM_VALUE_W,
  parameter int CNT_W      = 5,
  parameter int INIT_C10   = 8,
  parameter int INIT_C5    = 8,
  parameter int INIT_C1    = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 16
`ifdef LOW_STOCK_EN
  , parameter int LOW_THRESH = 2
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ret_coin,
  input  logic [VALUE_W-1:0] ret_value,
  input  logic               coin_sensed,
  input  logic               refill,
  output logic               busy,
  output logic               eject10,
  output logic               eject5,
  output logic               eject1,
  output logic               done,
  output logic               short,
  output logic [VALUE_W-1:0] owed,
  output logic               fault,
  output logic [CNT_W-1:0]   cnt10,
  output logic [CNT_W-1:0]   cnt5,
  output logic [CNT_W-1:0]   cnt1
`ifdef LOW_STOCK_EN
  , output logic             low_stock
`endif
);

  localparam int TMR_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  disp_state_e        state, next_state;
  denom_e             sel, pick;
  logic               pick_ok;
  logic [VALUE_W-1:0] remaining, sel_amt;
  logic               tmr_load, tmr_expire, tmr_run;
  logic [TMR_W-1:0]   tmr_val;
  logic               reload;

  always_comb begin
    pick    = D_1;
    pick_ok = 1'b0;
    if (remaining >= VALUE_W'(DENOM10) && cnt10 != '0) begin
      pick = D_10; pick_ok = 1'b1;
    end else if (remaining >= VALUE_W'(DENOM5) && cnt5 != '0) begin
      pick = D_5;  pick_ok = 1'b1;
    end else if (remaining >= VALUE_W'(DENOM1) && cnt1 != '0) begin
      pick = D_1;  pick_ok = 1'b1;
    end
  end

  always_comb begin
    case (sel)
      D_10:    sel_amt = VALUE_W'(DENOM10);
      D_5:     sel_amt = VALUE_W'(DENOM5);
      default: sel_amt = VALUE_W'(DENOM1);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (!refill && ret_coin) next_state = S_SELECT;
      S_SELECT: next_state = (remaining == '0 || !pick_ok) ? S_DONE : S_EJECT;
      S_EJECT: begin
        if (coin_sensed)     next_state = S_GAP;
        else if (tmr_expire) next_state = S_FAULT;
      end
      S_GAP:    if (tmr_expire || !tmr_run) next_state = S_SELECT;
      S_DONE:   next_state = S_IDLE;
      S_FAULT:  if (refill) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    eject10 = (state == S_EJECT) && (sel == D_10);
    eject5  = (state == S_EJECT) && (sel == D_5);
    eject1  = (state == S_EJECT) && (sel == D_1);
    done    = (state == S_DONE);
    short   = (state == S_DONE) && (remaining != '0);
    owed    = (state == S_DONE || state == S_FAULT) ? remaining : '0;
    fault   = (state == S_FAULT);
  end

  // Timer is reloaded on the edges entering EJECT (timeout window) and GAP (gap window).
  assign tmr_load = ((state == S_SELECT) && (next_state == S_EJECT)) ||
                    ((state == S_EJECT)  && (next_state == S_GAP));
  assign tmr_val  = (state == S_SELECT) ? TMR_W'(TIMEOUT - 1) : TMR_W'(GAP_CYCLES - 1);

  eject_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire),
    .running  (tmr_run)
  );

  assign reload = refill && (state == S_IDLE || state == S_FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      sel       <= D_1;
      cnt10     <= CNT_W'(INIT_C10);
      cnt5      <= CNT_W'(INIT_C5);
      cnt1      <= CNT_W'(INIT_C1);
    end else if (reload) begin
      cnt10     <= CNT_W'(INIT_C10);
      cnt5      <= CNT_W'(INIT_C5);
      cnt1      <= CNT_W'(INIT_C1);
    end else if (state == S_IDLE && ret_coin) begin
      remaining <= ret_value;
    end else if (state == S_SELECT) begin
      sel       <= pick;
    end else if (state == S_EJECT && coin_sensed) begin
      remaining <= remaining - sel_amt;
      case (sel)
        D_10:    if (cnt10 != '0) cnt10 <= cnt10 - 1'b1;
        D_5:     if (cnt5  != '0) cnt5  <= cnt5  - 1'b1;
        default: if (cnt1  != '0) cnt1  <= cnt1  - 1'b1;
      endcase
    end
  end

`ifdef LOW_STOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) low_stock <= 1'b0;
    else      low_stock <= (int'(cnt10) < LOW_THRESH) || (int'(cnt5) < LOW_THRESH) ||
                           (int'(cnt1) < LOW_THRESH);
  end
`endif

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout end of the vending controller's refund interface: consumes the `ret_coin` strobe and `ret_value` amount, and physically pays the amount out.
- Greedy split into 10/5/1 coins, one eject solenoid per denomination.
- Each ejected coin is confirmed by a drop sensor before the next coin starts.
- Tracks per-denomination inventory; reports shortfall and jams back to the controller and display logic.

Parameters:
- VALUE_W, 8, width of refund amount.
- CNT_W, 5, width of each inventory counter.
- INIT_C10, 8, 10-unit coins loaded at reset/refill.
- INIT_C5, 8, 5-unit coins loaded at reset/refill.
- INIT_C1, 16, 1-unit coins loaded at reset/refill.
- GAP_CYCLES, 2, idle cycles between consecutive ejects (≥1).
- TIMEOUT, 16, cycles an eject may wait for `coin_sensed` before declaring a jam.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- ret_coin  in  1  one-cycle refund request strobe.
- ret_value  in  VALUE_W  refund amount, sampled with `ret_coin`.
- coin_sensed  in  1  drop-sensor pulse; one coin left the hopper.
- refill  in  1  reload inventory to INIT_*; honoured in IDLE or FAULT only.
- busy  out  1  high in every state except IDLE.
- eject10, eject5, eject1  out  1 each  solenoid drives; at most one high at a time.
- done  out  1  one-cycle pulse when a payout ends, whether complete or short.
- short  out  1  valid with `done`: inventory could not cover the amount.
- owed  out  VALUE_W  undelivered remainder; valid with `done`, and held in FAULT.
- fault  out  1  jam detected; sticky until refill or reset.
- cnt10, cnt5, cnt1  out  CNT_W each  live inventory counts.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, except counts, which load INIT_C10/INIT_C5/INIT_C1.
  - Internal `remaining` register and timers are cleared.
  - A reset mid-eject drops the solenoid immediately.
- States: IDLE, SELECT, EJECT, GAP, DONE, FAULT.
- IDLE:
  - `ret_coin`=1 latches `ret_value` into `remaining`; go to SELECT next cycle.
  - `refill`=1 reloads counts; if both `refill` and `ret_coin` are high, refill wins and the request is dropped.
- SELECT (one cycle):
  - Choose the largest d in {10,5,1} with d ≤ `remaining` and count_d > 0.
  - If `remaining`=0: go to DONE with short=0, owed=0.
  - If no d qualifies and `remaining`>0: go to DONE with short=1, owed=`remaining`.
  - Otherwise go to EJECT with d latched.
- EJECT:
  - `eject_d` is held high and the timer counts.
  - On `coin_sensed`: count_d decrements, `remaining` -= d, solenoid drops next cycle, go to GAP.
  - If the timer reaches TIMEOUT without `coin_sensed`: go to FAULT. No decrement.
  - `coin_sensed` in any state other than EJECT is ignored.
- GAP: all ejects low for GAP_CYCLES, then SELECT.
- DONE:
  - `done`=1 for exactly one cycle, with short/owed valid; then IDLE.
  - short/owed clear in IDLE.
- FAULT:
  - fault=1, busy=1, all ejects low, owed=`remaining`.
  - `refill` clears the fault, reloads counts and returns to IDLE. No done pulse.
- Requests while busy: `ret_coin` outside IDLE is ignored; no queueing.
- Latency: `ret_coin` at cycle N → SELECT at N+1 → for a zero amount, `done` at N+2.
- Arithmetic: all unsigned; `remaining` never underflows because d ≤ `remaining` is guaranteed by SELECT.
- Counters: count_d saturates at 0 (a decrement at 0 is unreachable by construction).

Optional Feature:
- Macro: LOW_STOCK_EN.
- Defined:
  - Adds output `low_stock` (1 bit) and parameter LOW_THRESH (default 2).
  - `low_stock` is registered high whenever any count < LOW_THRESH; reset value is 0 (1 if any INIT_* < LOW_THRESH, from the first clock after reset).
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package `vm_pkg`:
  - Denomination constants DENOM10=10, DENOM5=5, DENOM1=1.
  - Dispenser state enum encoding.
  - VALUE_W default shared with the controller.
- Sub-module `eject_timer`:
  - Loadable down-counter used for both the TIMEOUT and GAP_CYCLES windows.
  - Outputs: expire pulse and running flag.
- Denomination select logic stays inline.

Test Plan:
- Reset, then `ret_coin` with value=27, sensor answering each eject after 3 cycles → eject order 10,10,5,1,1; counts 6/7/14; `done`=1, short=0, owed=0.
- Value=0 `ret_coin` at cycle N → `done` at N+2, no eject ever high, counts unchanged.
- Build with INIT_C10=1, INIT_C5=0, INIT_C1=2; value=15 → ejects 10,1,1; `done` with short=1, owed=3; counts 0/0/0.
- Value=10 with no `coin_sensed` → eject10 high for exactly 16 cycles, then fault=1, owed=10, cnt10=8; `refill` pulse → fault=0, IDLE; a new value=5 request pays normally.
- Drive rst low during EJECT → all ejects 0 immediately and counts back to INIT; a second `ret_coin` during GAP is ignored (only the first amount is paid).
- LOW_STOCK_EN build with INIT_C5=2: a payout using one 5-coin → `low_stock` rises the cycle after cnt5 becomes 1; `refill` → `low_stock`=0.
